// File: rtl/multdiv_pkg.sv
// Shared encodings for the multicycle multiply/divide unit.
package multdiv_pkg;
    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;
endpackage

// File: rtl/multdiv_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix-up.
module multdiv_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);
    assign result = negate ? (~value + WIDTH'(1)) : value;
endmodule

// File: rtl/multdiv_unit.sv
// Multicycle signed multiply (shift-add) / divide (restoring) on magnitudes, sign fixed at the end.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    state_t             state, state_n;
    op_t                op;
    logic [CNT_W-1:0]   cnt;
    logic               sign_neg, b_zero;
    logic [WIDTH:0]     mag_a, mag_b;
    // acc_hi: upper product half / remainder; acc_lo: multiplier bits / quotient
    logic [WIDTH:0]     acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic               start;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     hi_n, mul_sum, rem_sh;
    logic [WIDTH-1:0]   lo_n;
    logic [WIDTH+1:0]   trial;
    logic [2*WIDTH-1:0] mag_res, signed_res;
    logic [WIDTH-1:0]   done_res;
    logic               done_exc;

    assign start = ctrl_MULT | ctrl_DIV;
    assign busy  = (state != S_IDLE);

    multdiv_negate #(.WIDTH(WIDTH)) u_abs_a (
        .value(data_operandA), .negate(data_operandA[WIDTH-1]), .result(abs_a));
    multdiv_negate #(.WIDTH(WIDTH)) u_abs_b (
        .value(data_operandB), .negate(data_operandB[WIDTH-1]), .result(abs_b));

    // One iteration of either algorithm on the shared accumulator
    always_comb begin
        mul_sum = acc_lo[0] ? (acc_hi + mag_a) : acc_hi;
        rem_sh  = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        trial   = {1'b0, rem_sh} - {1'b0, mag_b};
        hi_n    = acc_hi;
        lo_n    = acc_lo;
        if (op == OP_MULT) begin
            hi_n = {1'b0, mul_sum[WIDTH:1]};
            lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end else if (!trial[WIDTH+1]) begin
            hi_n = trial[WIDTH:0];
            lo_n = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            hi_n = rem_sh;
            lo_n = {acc_lo[WIDTH-2:0], 1'b0};
        end
    end

    assign mag_res = (op == OP_MULT) ? {acc_hi[WIDTH-1:0], acc_lo}
                                     : {{WIDTH{1'b0}}, acc_lo};

    multdiv_negate #(.WIDTH(2*WIDTH)) u_fix (
        .value(mag_res), .negate(sign_neg), .result(signed_res));

    always_comb begin
        done_res = signed_res[WIDTH-1:0];
        done_exc = 1'b0;
        if (op == OP_MULT) begin
            done_exc = (|signed_res[2*WIDTH-1:WIDTH-1]) & ~(&signed_res[2*WIDTH-1:WIDTH-1]);
        end else if (b_zero) begin
            done_res = '0;
            done_exc = 1'b1;
        end else begin
            // a positive quotient with the top bit set can only be MIN / -1
            done_exc = ~sign_neg & acc_lo[WIDTH-1];
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start) state_n = S_RUN;
            S_RUN:   if (!start && cnt == CNT_W'(WIDTH-1)) state_n = S_DONE;
            S_DONE:  state_n = start ? S_RUN : S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt            <= '0;
            op             <= OP_MULT;
            sign_neg       <= 1'b0;
            b_zero         <= 1'b0;
            mag_a          <= '0;
            mag_b          <= '0;
            acc_hi         <= '0;
            acc_lo         <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (start) begin
                op       <= ctrl_MULT ? OP_MULT : OP_DIV;
                sign_neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                b_zero   <= (data_operandB == '0);
                mag_a    <= {1'b0, abs_a};
                mag_b    <= {1'b0, abs_b};
                acc_hi   <= '0;
                acc_lo   <= ctrl_MULT ? abs_b : abs_a;
                cnt      <= '0;
            end else if (state == S_RUN) begin
                acc_hi <= hi_n;
                acc_lo <= lo_n;
                cnt    <= cnt + CNT_W'(1);
            end else if (state == S_DONE) begin
                data_result    <= done_res;
                data_exception <= done_exc;
                data_resultRDY <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_multdiv_unit.sv
// Directed and random checks of multdiv_unit against an arithmetic reference model.
module tb_multdiv_unit;
    logic        clock = 1'b0;
    logic        reset, ctrl_MULT, ctrl_DIV;
    logic [31:0] data_operandA, data_operandB, data_result;
    logic        data_exception, data_resultRDY, busy;
    int          total = 0;
    int          bad = 0;

    always #5 clock = ~clock;

    multdiv_unit dut (
        .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .data_result(data_result), .data_exception(data_exception),
        .data_resultRDY(data_resultRDY), .busy(busy));

    // {exception, result} from plain signed arithmetic
    function automatic logic [32:0] model(input bit is_div, input logic signed [31:0] a,
                                          input logic signed [31:0] b);
        longint p;
        logic signed [31:0] lo;
        if (!is_div) begin
            p  = longint'(a) * longint'(b);
            lo = p[31:0];
            return {(p != longint'(lo)), lo};
        end
        if (b == 0) return {1'b1, 32'h0};
        if (a == 32'sh80000000 && b == -32'sd1) return {1'b1, 32'h80000000};
        lo = a / b;
        return {1'b0, lo};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_rdy(output int n);
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (data_resultRDY === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // Operands are scrambled after the start edge: only the start-edge values matter
    task automatic launch(input bit is_div, input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT = !is_div;
        ctrl_DIV  = is_div;
        data_operandA = a;
        data_operandB = b;
        tick();
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic run_check(input string tag, input bit is_div, input logic [31:0] a,
                             input logic [31:0] b);
        int n;
        logic [32:0] e;
        e = model(is_div, a, b);
        launch(is_div, a, b);
        chk({tag, "/busy"}, busy, 1);
        wait_rdy(n);
        chk({tag, "/latency"}, n, 33);
        chk({tag, "/result"}, data_result, e[31:0]);
        chk({tag, "/exc"}, data_exception, e[32]);
    endtask

    initial begin
        int n, pulses;
        bit is_div;
        logic [31:0] a, b;

        reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = '0; data_operandB = '0;
        tick(); tick();
        chk("rst/result", data_result, 0);
        chk("rst/exc", data_exception, 0);
        chk("rst/rdy", data_resultRDY, 0);
        chk("rst/busy", busy, 0);
        reset = 1'b0;

        run_check("mul_basic", 0, 32'd7, -32'sd6);
        tick();
        chk("mul_basic/pulse", data_resultRDY, 0);
        chk("mul_basic/idle", busy, 0);

        // reset sampled at E10 aborts the op
        launch(0, 32'd3, 32'd4);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid/busy", busy, 0);
        chk("rst_mid/result", data_result, 0);
        chk("rst_mid/exc", data_exception, 0);
        pulses = 0;
        repeat (40) begin
            tick();
            if (data_resultRDY === 1'b1) pulses++;
        end
        chk("rst_mid/no_rdy", pulses, 0);

        run_check("mul_ovf", 0, 32'h00010000, 32'h00010000);
        run_check("mul_min", 0, 32'h80000000, 32'h00000001);
        run_check("div_neg", 1, -32'sd7, 32'd2);
        run_check("div_zero", 1, 32'd5, 32'd0);
        run_check("div_ovf", 1, 32'h80000000, 32'hFFFFFFFF);

        // divide restarted by a multiply at E5
        launch(1, 32'd100, 32'd7);
        repeat (4) tick();
        launch(0, 32'd9, 32'd9);
        wait_rdy(n);
        chk("restart/latency", n, 33);
        chk("restart/result", data_result, 81);
        chk("restart/exc", data_exception, 0);

        // back-to-back start during the RDY cycle
        launch(1, 32'd100, 32'd7);
        chk("b2b/pulse", data_resultRDY, 0);
        wait_rdy(n);
        chk("b2b/latency", n, 33);
        chk("b2b/result", data_result, 14);
        chk("b2b/exc", data_exception, 0);

        for (int i = 0; i < 24; i++) begin
            is_div = 1'($urandom_range(0, 1));
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a = a >>> $urandom_range(0, 31);
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = 32'($urandom_range(0, 40)) - 32'd20;
                2: b = 32'd0;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_check(is_div ? "rnd_div" : "rnd_mul", is_div, a, b);
            tick();
            chk("rnd/pulse", data_resultRDY, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
